arf132b256e1r1w0cbbehcaa4acw_rd_port: RTL and testbench



---
 rtl/arf132b256e1r1w0cbbehcaa4acw_rd_pkg.sv | 14 +
 rtl/arf132b256e1r1w0cbbehcaa4acw_rd_port_if.sv | 28 ++
 rtl/arf132b256e1r1w0cbbehcaa4acw_rd_rsp_fifo.sv | 37 +++
 rtl/arf132b256e1r1w0cbbehcaa4acw_rd_port.sv | 60 ++++++
 tb/tb_arf132b256e1r1w0cbbehcaa4acw_rd_port.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rd_pkg.sv
// Shared constants and types for the 132b x 256 register-file read port.
// The write-bypass option is ARF132B256E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN.
package arf132b256e1r1w0cbbehcaa4acw_rd_pkg;

  localparam int unsigned DWIDTH        = 132;
  localparam int unsigned DEPTH         = 256;
  localparam int unsigned AWIDTH        = $clog2(DEPTH);
  localparam int unsigned RSP_BUF_DEPTH = 3;

  typedef logic [AWIDTH-1:0] addr_t;
  typedef logic [DWIDTH-1:0] data_t;
  typedef logic [1:0]        cnt_t;

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rd_port_if.sv
// Request, array-read, write-observe and response signals of the read port.
interface arf132b256e1r1w0cbbehcaa4acw_rd_port_if;
  import arf132b256e1r1w0cbbehcaa4acw_rd_pkg::*;

  logic  rd_req_vld;
  logic  rd_req_rdy;
  addr_t rd_req_addr;
  logic  arr_rd_en;
  addr_t arr_rd_addr;
  data_t arr_rd_data;
  logic  wr_en;
  addr_t wr_addr;
  data_t wr_data;
  logic  rd_rsp_vld;
  logic  rd_rsp_rdy;
  data_t rd_rsp_data;

  modport slave (
    input  rd_req_vld, rd_req_addr, arr_rd_data, wr_en, wr_addr, wr_data, rd_rsp_rdy,
    output rd_req_rdy, arr_rd_en, arr_rd_addr, rd_rsp_vld, rd_rsp_data
  );

  modport master (
    output rd_req_vld, rd_req_addr, arr_rd_data, wr_en, wr_addr, wr_data, rd_rsp_rdy,
    input  rd_req_rdy, arr_rd_en, arr_rd_addr, rd_rsp_vld, rd_rsp_data
  );

endinterface

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rd_rsp_fifo.sv
// In-order response buffer; entry 0 is always the head so dout is a flop.
module arf132b256e1r1w0cbbehcaa4acw_rd_rsp_fifo
  import arf132b256e1r1w0cbbehcaa4acw_rd_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  data_t din,
  output data_t dout,
  output cnt_t  occ
);

  data_t mem [RSP_BUF_DEPTH];
  cnt_t  cnt;
  cnt_t  wr_idx;

  // On a simultaneous pop the new entry lands one slot lower, behind the survivors.
  always_comb wr_idx = pop ? (cnt - 2'd1) : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int unsigned i = 0; i < RSP_BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < RSP_BUF_DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= din;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem[0];
  assign occ  = cnt;

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rd_port.sv
// Read-port controller: accept, one-cycle array read, 3-deep in-order response buffer.
// Define ARF132B256E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN to forward same-cycle write data.
module arf132b256e1r1w0cbbehcaa4acw_rd_port
  import arf132b256e1r1w0cbbehcaa4acw_rd_pkg::*;
(
  input logic clk,
  input logic rst,
  arf132b256e1r1w0cbbehcaa4acw_rd_port_if.slave bus
);

  logic  inflight;
  addr_t rd_addr_q;
  data_t cap_data;
  cnt_t  occ;
  logic  accept;
  logic  pop;

  assign accept = bus.rd_req_vld & bus.rd_req_rdy;
  assign pop    = bus.rd_rsp_vld & bus.rd_rsp_rdy;

  // Space is reserved for the inflight read so a push can never overflow the buffer.
  assign bus.rd_req_rdy = !rst && ((3'(occ) + 3'(inflight)) < 3'(RSP_BUF_DEPTH));
  assign bus.rd_rsp_vld = !rst && (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      inflight <= accept;
      if (accept) rd_addr_q <= bus.rd_req_addr;
    end
  end

  assign bus.arr_rd_en   = inflight;
  assign bus.arr_rd_addr = rd_addr_q;

`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN
  always_comb begin
    cap_data = bus.arr_rd_data;
    if (bus.wr_en && (bus.wr_addr == rd_addr_q)) cap_data = bus.wr_data;
  end
`else
  always_comb cap_data = bus.arr_rd_data;

  logic unused_wr;
  assign unused_wr = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
`endif

  arf132b256e1r1w0cbbehcaa4acw_rd_rsp_fifo u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (cap_data),
    .dout (bus.rd_rsp_data),
    .occ  (occ)
  );

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_rd_port.sv
// Scoreboard bench for the read port: the bench owns the array model and predicts every response.
module tb_arf132b256e1r1w0cbbehcaa4acw_rd_port;
  import arf132b256e1r1w0cbbehcaa4acw_rd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arf132b256e1r1w0cbbehcaa4acw_rd_port_if bus();

  arf132b256e1r1w0cbbehcaa4acw_rd_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Latch array stand-in: combinational read, write at the clock edge.
  data_t arr [DEPTH];
  assign bus.arr_rd_data = arr[bus.arr_rd_addr];
  always @(posedge clk) if (bus.wr_en) arr[bus.wr_addr] <= bus.wr_data;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic data_t rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DWIDTH-1:0];
  endfunction

  // Value a read of address a returns when the array is read in the current cycle.
  function automatic data_t expected_read(input addr_t a);
`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_RD_WR_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == a)) return bus.wr_data;
`endif
    return arr[a];
  endfunction

  // Scoreboard: expected responses in order, plus the one read that is in the array stage.
  data_t exp_q[$];
  logic  inf_m    = 1'b0;
  addr_t inf_addr = '0;
  logic  post_rst = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rdy_in_rst", bus.rd_req_rdy, 0);
      chk("vld_in_rst", bus.rd_rsp_vld, 0);
      exp_q.delete();
      inf_m    <= 1'b0;
      post_rst <= 1'b1;
    end else begin
      if (post_rst) begin
        chk("arr_addr_after_rst", bus.arr_rd_addr, 0);
        chk("rsp_data_after_rst", bus.rd_rsp_data, 0);
        post_rst <= 1'b0;
      end
      chk("req_rdy", bus.rd_req_rdy, (exp_q.size() + int'(inf_m)) < 3);
      chk("rsp_vld", bus.rd_rsp_vld, exp_q.size() != 0);
      chk("arr_rd_en", bus.arr_rd_en, inf_m);
      if (bus.rd_rsp_vld && bus.rd_rsp_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got %h want none at %0t", bus.rd_rsp_data, $time);
        end else begin
          chk("rsp_data", bus.rd_rsp_data, exp_q.pop_front());
        end
      end
      if (inf_m) begin
        chk("arr_rd_addr", bus.arr_rd_addr, inf_addr);
        exp_q.push_back(expected_read(inf_addr));
      end
      inf_m    <= bus.rd_req_vld && bus.rd_req_rdy;
      inf_addr <= bus.rd_req_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus.rd_req_vld = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst             = 1'b1;
    bus.rd_req_vld  = 1'b0;
    bus.rd_req_addr = '0;
    bus.rd_rsp_rdy  = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;

    // Fill the array through the write port while the controller is held in reset.
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc();
      bus.wr_en   = 1'b1;
      bus.wr_addr = addr_t'(i);
      bus.wr_data = rand_word();
    end
    cyc();
    bus.wr_addr = 8'h2A;
    bus.wr_data = {4'h5, {4{32'hA5A5_0F0F}}};
    cyc();
    bus.wr_en      = 1'b0;
    rst            = 1'b0;
    bus.rd_rsp_rdy = 1'b1;
    idle(2);

    // Single read of the preset pattern.
    bus.rd_req_vld  = 1'b1;
    bus.rd_req_addr = 8'h2A;
    cyc();
    idle(4);

    // Back-to-back stream, addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = addr_t'(i);
      cyc();
    end
    idle(4);

    // Backpressure: fill the buffer, then release while still requesting.
    bus.rd_rsp_rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) bus.rd_rsp_rdy = 1'b1;
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = addr_t'($urandom_range(255));
      cyc();
    end
    idle(6);

    // Write to the same address during the array-read cycle.
    bus.rd_req_vld  = 1'b1;
    bus.rd_req_addr = 8'd5;
    cyc();
    bus.rd_req_vld = 1'b0;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 8'd5;
    bus.wr_data    = '1;
    cyc();
    bus.wr_en = 1'b0;
    idle(4);

    // Two buffered plus one inflight, then pop and push on the same edge.
    bus.rd_rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = addr_t'(10 + i);
      cyc();
    end
    bus.rd_req_vld = 1'b0;
    bus.rd_rsp_rdy = 1'b1;
    cyc();
    bus.rd_rsp_rdy = 1'b0;
    idle(2);
    bus.rd_rsp_rdy = 1'b1;
    idle(6);

    // Reset with two responses buffered and one read inflight.
    bus.rd_rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req_vld  = 1'b1;
      bus.rd_req_addr = addr_t'(20 + i);
      cyc();
    end
    bus.rd_req_vld = 1'b0;
    rst            = 1'b1;
    cyc();
    rst            = 1'b0;
    bus.rd_rsp_rdy = 1'b1;
    idle(4);

    // Random traffic with colliding writes, backpressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      bus.rd_req_vld  = ($urandom_range(3) != 0);
      bus.rd_req_addr = addr_t'($urandom_range(15));
      bus.rd_rsp_rdy  = ($urandom_range(3) != 0);
      bus.wr_en       = $urandom_range(1) == 1;
      bus.wr_addr     = addr_t'($urandom_range(15));
      bus.wr_data     = rand_word();
      rst             = ($urandom_range(149) == 0);
      cyc();
    end
    rst            = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_rsp_rdy = 1'b1;
    idle(10);

    @(negedge clk);
    #1;
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
